// File: rtl/peak_level_detector.sv
// Peak-envelope level detector: instant attack, sample-counted hold, exponential decay.
// Optional clip indicator with hold is built when CLIP_HOLD_EN is defined.
module peak_level_detector #(
    parameter int DATA_BITS         = 24,
    parameter int HOLD_SAMPLES      = 4800,
    parameter int HOLD_BITS         = 16,
    parameter int DECAY_SHIFT       = 10,
    parameter int CLIP_HOLD_SAMPLES = 24000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_valid,
    input  logic                 clear,
    output logic [DATA_BITS-1:0] level_out,
    output logic                 level_valid,
    output logic                 clip_out,
    output logic [1:0]           dbg_state
);
    localparam int MW = DATA_BITS - 1;
    localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, DECAY = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [MW-1:0]         mag_q, abs_mag;
    logic                  valid1_q;
    logic [MW-1:0]         level_q, level_d;
    logic [HOLD_BITS-1:0]  hold_q, hold_d;
    logic                  level_valid_q, level_valid_d;
    logic [MW-1:0]         step, diff, decayed;

    // Low bits of -x equal ~x+1; the most negative input saturates to full scale.
    always_comb begin
        abs_mag = sample_in[MW-1:0];
        if (sample_in[DATA_BITS-1]) begin
            if (sample_in[MW-1:0] == '0) abs_mag = MAG_MAX;
            else                         abs_mag = ~sample_in[MW-1:0] + MW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag_q    <= '0;
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= sample_valid & ~clear;
            if (sample_valid) mag_q <= abs_mag;
        end
    end

    always_comb begin
        step = level_q >> DECAY_SHIFT;
        if (step == '0) step = MW'(1);
        diff    = level_q - step;
        decayed = (diff > mag_q) ? diff : mag_q;
    end

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        hold_d        = hold_q;
        level_valid_d = 1'b0;
        if (clear) begin
            state_d       = IDLE;
            level_d       = '0;
            hold_d        = '0;
            level_valid_d = 1'b1;
        end else if (valid1_q) begin
            level_valid_d = 1'b1;
            case (state_q)
                IDLE: begin
                    level_d = '0;
                    if (mag_q != '0) begin
                        level_d = mag_q;
                        hold_d  = HOLD_BITS'(HOLD_SAMPLES);
                        state_d = (HOLD_SAMPLES == 0) ? DECAY : HOLD;
                    end
                end
                HOLD: begin
                    if (mag_q > level_q) begin
                        level_d = mag_q;
                        hold_d  = HOLD_BITS'(HOLD_SAMPLES);
                    end else begin
                        hold_d = (hold_q == '0) ? '0 : hold_q - HOLD_BITS'(1);
                        if (hold_q <= HOLD_BITS'(1)) state_d = DECAY;
                    end
                end
                DECAY: begin
                    if (mag_q > level_q) begin
                        level_d = mag_q;
                        hold_d  = HOLD_BITS'(HOLD_SAMPLES);
                        state_d = HOLD;
                    end else begin
                        level_d = decayed;
                        if (decayed == '0) state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            level_q       <= '0;
            hold_q        <= '0;
            level_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            hold_q        <= hold_d;
            level_valid_q <= level_valid_d;
        end
    end

    assign level_out   = {level_q, 1'b0};
    assign level_valid = level_valid_q;
    assign dbg_state   = state_q;

`ifdef CLIP_HOLD_EN
    localparam int CW = $clog2(CLIP_HOLD_SAMPLES + 2);
    logic [CW-1:0] clip_cnt_q, clip_cnt_d;

    // Counter non-zero means the indicator is lit; each clip re-arms it.
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (clear) begin
            clip_cnt_d = '0;
        end else if (valid1_q) begin
            if (mag_q == MAG_MAX)        clip_cnt_d = CW'(CLIP_HOLD_SAMPLES);
            else if (clip_cnt_q != '0)   clip_cnt_d = clip_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) clip_cnt_q <= '0;
        else      clip_cnt_q <= clip_cnt_d;
    end

    assign clip_out = (clip_cnt_q != '0);
`else
    logic unused_clip_cfg;
    assign unused_clip_cfg = (CLIP_HOLD_SAMPLES != 0);
    assign clip_out        = 1'b0;
`endif

endmodule

// File: tb/tb_peak_level_detector.sv
// Self-checking bench for peak_level_detector: vector table plus hand sequences,
// scoreboard of expected {clip, level} and arrival cycle.
module tb_peak_level_detector;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sample_in;
    logic         sample_valid;
    logic         clear;
    logic [W-1:0] level_out;
    logic         level_valid;
    logic         clip_out;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W:0] exp_q[$];
    int         exp_cyc_q[$];

    typedef struct {
        logic         v;
        logic         c;
        logic [W-1:0] s;
        logic [W-1:0] lvl;
        logic         clp;
    } vec_t;
    vec_t tbl[$];

    peak_level_detector #(
        .DATA_BITS(W), .HOLD_SAMPLES(2), .HOLD_BITS(16),
        .DECAY_SHIFT(2), .CLIP_HOLD_SAMPLES(3)
    ) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .clear(clear), .level_out(level_out), .level_valid(level_valid),
        .clip_out(clip_out), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic clipx(input logic c);
`ifdef CLIP_HOLD_EN
        return c;
`else
        return 1'b0 & c;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every level_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && level_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got level 0x%0h expected no pulse (cycle %0d)", level_out, cyc);
            end else begin
                logic [W:0] e;
                int         ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("level", 32'(level_out), 32'(e[W-1:0]));
                check("clip", 32'(clip_out), 32'(e[W]));
                check("latency", 32'(cyc), 32'(ec));
            end
        end
    end

    task automatic apply(input logic v, input logic c, input logic [W-1:0] s,
                         input logic [W-1:0] lvl, input logic clp);
        sample_valid = v;
        clear        = c;
        sample_in    = s;
        if (c) begin
            exp_q.push_back({clipx(clp), lvl});
            exp_cyc_q.push_back(cyc + 1);
        end else if (v) begin
            exp_q.push_back({clipx(clp), lvl});
            exp_cyc_q.push_back(cyc + 2);
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic add(input logic v, input logic c, input logic [W-1:0] s,
                       input logic [W-1:0] lvl, input logic clp);
        vec_t r;
        r.v = v; r.c = c; r.s = s; r.lvl = lvl; r.clp = clp;
        tbl.push_back(r);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; sample_valid = 1'b0; clear = 1'b0; sample_in = '0;
        #1;
        check("rst_level", 32'(level_out), 32'd0);
        check("rst_valid", 32'(level_valid), 32'd0);
        check("rst_clip", 32'(clip_out), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Attack, sign, equal-not-peak, decay, re-attack.
        add(0, 1, 24'h000000, 24'h000000, 0);
        add(0, 0, 24'h000000, 24'h000000, 0);
        add(1, 0, 24'h400000, 24'h800000, 0);
        add(1, 0, 24'hC00000, 24'h800000, 0);
        add(1, 0, 24'h000000, 24'h800000, 0);
        add(1, 0, 24'h000000, 24'h600000, 0);
        add(1, 0, 24'h300000, 24'h600000, 0);
        add(1, 0, 24'h500000, 24'hA00000, 0);
        add(0, 0, 24'h000000, 24'h000000, 0);
        add(0, 1, 24'h000000, 24'h000000, 0);
        add(0, 0, 24'h000000, 24'h000000, 0);
        // Hold then decay from 0x100.
        add(1, 0, 24'h000100, 24'h000200, 0);
        add(1, 0, 24'h000000, 24'h000200, 0);
        add(1, 0, 24'h000000, 24'h000200, 0);
        add(1, 0, 24'h000000, 24'h000180, 0);
        add(1, 0, 24'h000000, 24'h000120, 0);
        add(1, 0, 24'h000000, 24'h0000D8, 0);
        // Back-to-back ramp.
        for (int i = 1; i <= 8; i++)
            add(1, 0, 24'(i * 256), 24'(i * 512), 0);
        add(1, 0, 24'hFFF700, 24'h001200, 0);
        add(0, 0, 24'h000000, 24'h000000, 0);
        add(0, 1, 24'h000000, 24'h000000, 0);
        add(0, 0, 24'h000000, 24'h000000, 0);
        // Clip saturation and clip hold.
        add(1, 0, 24'h800000, 24'hFFFFFE, 1);
        add(1, 0, 24'h000000, 24'hFFFFFE, 1);
        add(1, 0, 24'h000000, 24'hFFFFFE, 1);
        add(1, 0, 24'h000000, 24'hC00000, 0);
        add(1, 0, 24'h7FFFFF, 24'hFFFFFE, 1);
        add(0, 0, 24'h000000, 24'h000000, 0);
        // Clear wins over a simultaneous sample.
        add(1, 1, 24'h800000, 24'h000000, 0);
        add(0, 0, 24'h000000, 24'h000000, 0);
        add(0, 0, 24'h000000, 24'h000000, 0);

        foreach (tbl[i]) apply(tbl[i].v, tbl[i].c, tbl[i].s, tbl[i].lvl, tbl[i].clp);
        drain("table_drain");

        // Minimum step of 1 down to zero, back to IDLE.
        apply(1, 0, 24'h000003, 24'h000006, 0);
        apply(1, 0, 24'h000000, 24'h000006, 0);
        apply(1, 0, 24'h000000, 24'h000006, 0);
        apply(1, 0, 24'h000000, 24'h000004, 0);
        apply(1, 0, 24'h000000, 24'h000002, 0);
        apply(1, 0, 24'h000000, 24'h000000, 0);
        drain("minstep_drain");
        check("minstep_state_idle", 32'(dbg_state), 32'd0);

        // Decay floored at incoming magnitude.
        apply(1, 0, 24'h000100, 24'h000200, 0);
        apply(1, 0, 24'h000000, 24'h000200, 0);
        apply(1, 0, 24'h000000, 24'h000200, 0);
        apply(1, 0, 24'h0000F0, 24'h0001E0, 0);
        drain("floor_drain");
        check("floor_state_decay", 32'(dbg_state), 32'd2);

        // No samples: everything frozen.
        repeat (1000) @(posedge clk);
        #1;
        check("idle_frozen_level", 32'(level_out), 32'h0001E0);
        check("idle_frozen_state", 32'(dbg_state), 32'd2);

        // Asynchronous reset mid-stream.
        apply(1, 0, 24'h091A2B, 24'h123456, 0);
        drain("prereset_drain");
        check("prereset_level", 32'(level_out), 32'h123456);
        sample_valid = 1'b1;
        sample_in    = 24'h7FFFFF;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_level", 32'(level_out), 32'd0);
        check("midrst_valid", 32'(level_valid), 32'd0);
        check("midrst_clip", 32'(clip_out), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        apply(1, 0, 24'h000010, 24'h000020, 0);
        drain("postreset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
